onehot_pulse_dec: RTL and testbench

Sequenced 3-to-8 decoder: the receive-side counterpart of the 8-to-3 priority encoder. It accepts 3-bit binary codes over a valid/ready handshake and drives the matching one-hot line on an 8-bit output for a fixed number of cycles, followed by a programmable idle gap. A one-entry holding register lets the next code be accepted while the current pulse is in flight. It sits where encoded channel indices must be turned back into per-line strobes, such as select lines and interrupt acknowledges.

---
 rtl/onehot_pulse_dec_pkg.sv | 13 +
 rtl/onehot_pulse_dec_if.sv | 26 ++
 rtl/onehot_pulse_dec_dec3to8.sv | 14 +
 rtl/onehot_pulse_dec.sv | 115 +++++++++++
 tb/tb_onehot_pulse_dec.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/onehot_pulse_dec_pkg.sv
// Shared types and widths for the sequenced 3-to-8 one-hot pulse decoder.
package onehot_dec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dec_state_t;

  localparam int CODE_W = 3;
  localparam int LINES  = 8;

endpackage

// File: rtl/onehot_pulse_dec_if.sv
// Code input handshake and decoded-line outputs of the one-hot pulse decoder.
// Handshake: a code transfers on a rising edge where bin_valid && bin_ready; once
// bin_valid rises the source holds it and bin stable until that edge, and bin_ready
// never depends on bin_valid in the same cycle.
interface onehot_pulse_dec_if;
  import onehot_dec_pkg::*;

  logic [CODE_W-1:0] bin;
  logic              bin_valid;
  logic              bin_ready;
  logic [LINES-1:0]  out;
  logic              active;
  logic              done;
  dec_state_t        state;

  modport master (
    output bin, bin_valid,
    input  bin_ready, out, active, done, state
  );

  modport slave (
    input  bin, bin_valid,
    output bin_ready, out, active, done, state
  );

endinterface

// File: rtl/onehot_pulse_dec_dec3to8.sv
// Combinational binary-to-one-hot decoder; every code maps to exactly one line.
module dec3to8
  import onehot_dec_pkg::*;
(
  input  logic [CODE_W-1:0] bin,
  output logic [LINES-1:0]  out
);

  always_comb begin
    out      = '0;
    out[bin] = 1'b1;
  end

endmodule

// File: rtl/onehot_pulse_dec.sv
// Sequenced 3-to-8 decoder: drives the one-hot line of each accepted code for HOLD
// cycles, then forces GAP idle cycles; a one-entry holding register queues the next code.
module onehot_pulse_dec
  import onehot_dec_pkg::*;
#(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  onehot_pulse_dec_if.slave  bus
);

  localparam int MAXV  = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W = ($clog2(MAXV + 1) < 1) ? 1 : $clog2(MAXV + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  dec_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CODE_W-1:0] act_code, act_n;
  logic [CODE_W-1:0] hold_code, hold_code_n;
  logic              hold_full, hold_full_n;
  logic              xfer;
  logic              end_gap;
  logic [LINES-1:0]  dec_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      act_code  <= '0;
      hold_code <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      act_code  <= act_n;
      hold_code <= hold_code_n;
      hold_full <= hold_full_n;
    end
  end

  assign xfer = bus.bin_valid && !hold_full;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    act_n       = act_code;
    hold_code_n = hold_code;
    hold_full_n = hold_full;
    end_gap     = 1'b0;

    case (state)
      IDLE: begin
        if (xfer) begin
          act_n   = bus.bin;
          state_n = DRIVE;
          cnt_n   = HOLD_LD;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          if (GAP > 0) begin
            state_n = onehot_dec_pkg::GAP;
            cnt_n   = GAP_LD;
          end else begin
            end_gap = 1'b1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      onehot_dec_pkg::GAP: begin
        if (cnt == '0) end_gap = 1'b1;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // A held code wins at end of gap; ready is low then, so no new code can collide.
    if (end_gap) begin
      if (hold_full) begin
        act_n       = hold_code;
        hold_full_n = 1'b0;
        state_n     = DRIVE;
        cnt_n       = HOLD_LD;
      end else if (xfer) begin
        act_n   = bus.bin;
        state_n = DRIVE;
        cnt_n   = HOLD_LD;
      end else begin
        state_n = IDLE;
      end
    end else if (xfer && state != IDLE) begin
      hold_code_n = bus.bin;
      hold_full_n = 1'b1;
    end
  end

  dec3to8 u_dec (
    .bin (act_code),
    .out (dec_out)
  );

  assign bus.bin_ready = !hold_full;
  assign bus.active    = (state == DRIVE);
  assign bus.out       = (state == DRIVE) ? dec_out : '0;
  assign bus.done      = (state == DRIVE) && (cnt == '0);
  assign bus.state     = state;

endmodule

// File: tb/tb_onehot_pulse_dec.sv
// Bench for onehot_pulse_dec: one instance with HOLD=4/GAP=1, one with HOLD=1/GAP=0.
module tb_onehot_pulse_dec;
  import onehot_dec_pkg::*;

  localparam int A_HOLD = 4;
  localparam int A_GAP  = 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  onehot_pulse_dec_if a_if();
  onehot_pulse_dec_if b_if();

  onehot_pulse_dec #(.HOLD(A_HOLD), .GAP(A_GAP)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  onehot_pulse_dec #(.HOLD(1), .GAP(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a(input string tag);
    int budget;
    budget = 50;
    while (!a_if.bin_ready && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // scoreboard for the randomized phase on instance A
  logic [CODE_W-1:0] exp_q[$];
  logic              sb_on;
  int                run_len;
  int                gap_len;
  logic [LINES-1:0]  cur_out;

  always @(negedge clk) begin
    if (sb_on) begin
      if (a_if.bin_valid && a_if.bin_ready) exp_q.push_back(a_if.bin);
      if (a_if.active) begin
        if (run_len == 0) begin
          check("sb_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) cur_out = LINES'(1) << exp_q.pop_front();
          check("sb_gap", 32'(gap_len >= A_GAP), 32'd1);
        end
        check("sb_out", 32'(a_if.out), 32'(cur_out));
        run_len++;
        if (a_if.done) begin
          check("sb_len", run_len, A_HOLD);
          run_len = 0;
          gap_len = 0;
        end
      end else begin
        check("sb_idle_out", 32'(a_if.out), 32'd0);
        check("sb_cut_pulse", run_len, 0);
        gap_len++;
      end
    end
  end

  initial begin
    logic [LINES-1:0] e;
    logic [LINES-1:0] seen;
    int               c;

    n_checks = 0;
    n_fail   = 0;
    sb_on    = 1'b0;
    run_len  = 0;
    gap_len  = 1000;
    cur_out  = '0;
    rst      = 1'b1;
    a_if.bin = 3'd3;  a_if.bin_valid = 1'b1;
    b_if.bin = 3'd6;  b_if.bin_valid = 1'b1;

    // reset with valid high: no transfer, reset values everywhere
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_out_a", 32'(a_if.out), 32'h0);
      check("rst_active_a", 32'(a_if.active), 32'd0);
      check("rst_done_a", 32'(a_if.done), 32'd0);
      check("rst_ready_a", 32'(a_if.bin_ready), 32'd1);
      check("rst_state_a", 32'(a_if.state), 32'(IDLE));
      check("rst_out_b", 32'(b_if.out), 32'h0);
      check("rst_ready_b", 32'(b_if.bin_ready), 32'd1);
    end
    rst = 1'b0;
    a_if.bin_valid = 1'b0;
    b_if.bin_valid = 1'b0;
    step();
    check("post_rst_state_a", 32'(a_if.state), 32'(IDLE));
    check("post_rst_out_b", 32'(b_if.out), 32'h0);

    // single code 5
    a_if.bin = 3'd5; a_if.bin_valid = 1'b1;
    step();
    a_if.bin_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("single_out_%0d", i), 32'(a_if.out), 32'h20);
      check($sformatf("single_done_%0d", i), 32'(a_if.done), 32'(i == 4));
      check($sformatf("single_active_%0d", i), 32'(a_if.active), 32'd1);
      check($sformatf("single_ready_%0d", i), 32'(a_if.bin_ready), 32'd1);
      step();
    end
    check("single_gap_out", 32'(a_if.out), 32'h0);
    check("single_gap_state", 32'(a_if.state), 32'(onehot_dec_pkg::GAP));
    check("single_gap_done", 32'(a_if.done), 32'd0);
    step();
    check("single_idle", 32'(a_if.state), 32'(IDLE));

    // backpressure: 3 then 6 back to back
    a_if.bin = 3'd3; a_if.bin_valid = 1'b1;
    step();
    check("bp_out_1", 32'(a_if.out), 32'h08);
    check("bp_ready_1", 32'(a_if.bin_ready), 32'd1);
    a_if.bin = 3'd6;
    step();
    a_if.bin_valid = 1'b0;
    for (c = 2; c <= 9; c++) begin
      e = (c <= 4) ? 8'h08 : (c == 5) ? 8'h00 : 8'h40;
      check($sformatf("bp_out_%0d", c), 32'(a_if.out), 32'(e));
      check($sformatf("bp_ready_%0d", c), 32'(a_if.bin_ready), 32'(c >= 6));
      check($sformatf("bp_done_%0d", c), 32'(a_if.done), 32'(c == 4 || c == 9));
      step();
    end
    check("bp_tail_out", 32'(a_if.out), 32'h0);
    step();
    check("bp_tail_idle", 32'(a_if.state), 32'(IDLE));

    // contiguous pulses, HOLD=1 GAP=0
    b_if.bin = 3'd0; b_if.bin_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i < 7) b_if.bin = 3'(i + 1);
      else       b_if.bin_valid = 1'b0;
      e = 8'd1 << i;
      check($sformatf("contig_out_%0d", i), 32'(b_if.out), 32'(e));
      check($sformatf("contig_done_%0d", i), 32'(b_if.done), 32'd1);
      check($sformatf("contig_ready_%0d", i), 32'(b_if.bin_ready), 32'd1);
    end
    step();
    check("contig_end_out", 32'(b_if.out), 32'h0);
    check("contig_end_state", 32'(b_if.state), 32'(IDLE));

    // mid-pulse reset with a held code
    a_if.bin = 3'd7; a_if.bin_valid = 1'b1;
    step();
    a_if.bin = 3'd2;
    step();
    a_if.bin_valid = 1'b0;
    check("mrst_out_pre", 32'(a_if.out), 32'h80);
    check("mrst_ready_pre", 32'(a_if.bin_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_out", 32'(a_if.out), 32'h0);
    check("mrst_done", 32'(a_if.done), 32'd0);
    check("mrst_ready", 32'(a_if.bin_ready), 32'd1);
    check("mrst_state", 32'(a_if.state), 32'(IDLE));
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen |= a_if.out;
    end
    check("mrst_no_held_emit", 32'(seen), 32'h0);

    // randomized traffic checked by the scoreboard
    sb_on = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int idle;
      idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++) step();
      a_if.bin = 3'($urandom_range(0, 7));
      a_if.bin_valid = 1'b1;
      wait_ready_a("rand");
      step();
      a_if.bin_valid = 1'b0;
    end
    for (int k = 0; k < 20; k++) step();
    sb_on = 1'b0;
    check("sb_drained", exp_q.size(), 0);
    check("sb_run_closed", run_len, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
